// File: rtl/matu_pkg.sv
// Shared definitions for the matrix-tile accumulator.
//   state_t        : tile FSM states (IDLE = no tile open, ACC = tile open)
//   requant_width  : internal width used while rounding/shifting one element,
//                    wide enough that acc + bias + rounding never wraps
//   shift_width    : width of the requantisation shift amount
package matu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

  // Three guard bits: one for the bias add, one for the rounding add and
  // one so unsigned values stay positive when viewed as signed.
  function automatic int requant_width(input int acc_width);
    return acc_width + 3;
  endfunction

  function automatic int shift_width(input int acc_width);
    return $clog2(acc_width);
  endfunction

endpackage

// File: rtl/matu_requant.sv
// Requantises one accumulator element: adds the column bias, adds the
// rounding constant 2^(shift-1) when shift > 0, shifts right (arithmetic
// for signed tiles, logical for unsigned) and saturates to OUT_WIDTH.
// Purely combinational; the caller registers the result.
//   acc_sum   : accumulator value including the last beat's product
//   bias      : per-column bias, interpreted with the tile's signedness
//   shift     : right shift amount
//   is_signed : tile mode
//   result    : saturated OUT_WIDTH value
module matu_requant
  import matu_pkg::*;
#(
  parameter int ACC_WIDTH   = 24,
  parameter int IN_WIDTH    = 8,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
  input  logic [ACC_WIDTH-1:0]   acc_sum,
  input  logic [IN_WIDTH-1:0]    bias,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   is_signed,
  output logic [OUT_WIDTH-1:0]   result
);

  localparam int EW = requant_width(ACC_WIDTH);

  localparam logic signed [EW-1:0] SMAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [EW-1:0] UMAX = {{(EW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic signed [EW-1:0] acc_x;
  logic signed [EW-1:0] bias_x;
  logic signed [EW-1:0] rnd_x;
  logic signed [EW-1:0] sum_x;
  logic signed [EW-1:0] shf_x;

  always_comb begin
    acc_x  = {{(EW-ACC_WIDTH){is_signed & acc_sum[ACC_WIDTH-1]}}, acc_sum};
    bias_x = {{(EW-IN_WIDTH){is_signed & bias[IN_WIDTH-1]}}, bias};
    rnd_x  = '0;
    if (shift != '0) begin
      rnd_x = EW'(1) << (shift - SHIFT_WIDTH'(1));
    end
    sum_x = acc_x + bias_x + rnd_x;
    if (is_signed) begin
      shf_x = sum_x >>> shift;
    end else begin
      shf_x = sum_x >> shift;
    end
    result = shf_x[OUT_WIDTH-1:0];
    if (is_signed) begin
      if (shf_x > SMAX) begin
        result = SMAX[OUT_WIDTH-1:0];
      end else if (shf_x < SMIN) begin
        result = SMIN[OUT_WIDTH-1:0];
      end
    end else if (shf_x > UMAX) begin
      // unsigned values are non-negative here, so only the top bound matters
      result = UMAX[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/matu_acc.sv
// Outer-product tile accumulator. Each accepted beat adds i_a[r]*i_b[c]
// into acc[r][c]; the beat flagged i_last also biases, rounds, shifts and
// saturates every element into o_c, which is presented with a valid/ready
// handshake one cycle later.
//   i_clk, i_rst         : clock, asynchronous active-low reset
//   i_pre_valid/o_pre_ready : input beat handshake
//   i_a, i_b             : A column slice (ROWS) and B row slice (COLS)
//   i_last               : beat closes the tile
//   i_signed             : operand mode, latched on the tile's first beat
//   i_shift, i_d         : requant shift and per-column bias (last beat)
//   o_post_valid/i_post_ready : result handshake
//   o_c                  : result tile
//   o_ovf                : sticky flag, tile ran past KMAX beats
module matu_acc
  import matu_pkg::*;
#(
  parameter int ROWS      = 3,
  parameter int COLS      = 3,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 16,
  parameter int KMAX      = 16
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_pre_valid,
  output logic                                      o_pre_ready,
  input  logic [ROWS-1:0][IN_WIDTH-1:0]             i_a,
  input  logic [COLS-1:0][IN_WIDTH-1:0]             i_b,
  input  logic                                      i_last,
  input  logic                                      i_signed,
  input  logic [$clog2(ACC_WIDTH)-1:0]              i_shift,
  input  logic [COLS-1:0][IN_WIDTH-1:0]             i_d,
  output logic                                      o_post_valid,
  input  logic                                      i_post_ready,
  output logic [ROWS-1:0][COLS-1:0][OUT_WIDTH-1:0]  o_c,
  output logic                                      o_ovf
);

  localparam int SW = shift_width(ACC_WIDTH);
  localparam int CW = $clog2(KMAX + 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            ovf_reg, ovf_next;
  logic            mode_reg;
  logic            post_valid_reg;
  logic            tile_signed;
  logic            beat_accept;

  assign o_pre_ready  = ~post_valid_reg | i_post_ready;
  assign beat_accept  = i_pre_valid & o_pre_ready;
  assign o_post_valid = post_valid_reg;
  assign o_ovf        = ovf_reg;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;
    // the first beat of a tile uses the live mode; later beats the latched one
    tile_signed = (state_reg == ST_IDLE) ? i_signed : mode_reg;
    if (beat_accept) begin
      if (i_last) begin
        state_next = ST_IDLE;
        count_next = '0;
      end else begin
        state_next = ST_ACC;
        if (count_reg == CW'(KMAX)) begin
          ovf_next = 1'b1;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      ovf_reg        <= 1'b0;
      mode_reg       <= 1'b0;
      post_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      if (beat_accept && state_reg == ST_IDLE) begin
        mode_reg <= i_signed;
      end
      if (beat_accept && i_last) begin
        post_valid_reg <= 1'b1;
      end else if (i_post_ready) begin
        post_valid_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic [ACC_WIDTH-1:0] acc_reg;
      logic [ACC_WIDTH-1:0] a_x, b_x, prod, sum;
      logic [OUT_WIDTH-1:0] req;
      logic [OUT_WIDTH-1:0] c_reg;

      // extended operands make the truncated product equal the wrapped
      // full product for both signed and unsigned modes
      assign a_x  = {{(ACC_WIDTH-IN_WIDTH){tile_signed & i_a[gi][IN_WIDTH-1]}}, i_a[gi]};
      assign b_x  = {{(ACC_WIDTH-IN_WIDTH){tile_signed & i_b[gj][IN_WIDTH-1]}}, i_b[gj]};
      assign prod = a_x * b_x;
      assign sum  = acc_reg + prod;

      matu_requant #(
        .ACC_WIDTH  (ACC_WIDTH),
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT_WIDTH(SW)
      ) u_requant (
        .acc_sum  (sum),
        .bias     (i_d[gj]),
        .shift    (i_shift),
        .is_signed(tile_signed),
        .result   (req)
      );

      always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
          acc_reg <= '0;
          c_reg   <= '0;
        end else if (beat_accept) begin
          if (i_last) begin
            acc_reg <= '0;
            c_reg   <= req;
          end else begin
            acc_reg <= sum;
          end
        end
      end

      assign o_c[gi][gj] = c_reg;
    end
  end

endmodule

// File: tb/tb_matu_acc.sv
module tb_matu_acc;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int IW   = 8;
  localparam int OW   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_pre_valid = 1'b0;
  logic o_pre_ready;
  logic [ROWS-1:0][IW-1:0] i_a = '0;
  logic [COLS-1:0][IW-1:0] i_b = '0;
  logic i_last = 1'b0;
  logic i_signed = 1'b0;
  logic [4:0] i_shift = '0;
  logic [COLS-1:0][IW-1:0] i_d = '0;
  logic o_post_valid;
  logic i_post_ready = 1'b0;
  logic [ROWS-1:0][COLS-1:0][OW-1:0] o_c;
  logic o_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matu_acc dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_pre_valid (i_pre_valid),
    .o_pre_ready (o_pre_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .i_last      (i_last),
    .i_signed    (i_signed),
    .i_shift     (i_shift),
    .i_d         (i_d),
    .o_post_valid(o_post_valid),
    .i_post_ready(i_post_ready),
    .o_c         (o_c),
    .o_ovf       (o_ovf)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  d;
    bit          sgn;
    logic [4:0]  sh;
    int          beats;
    logic [15:0] exp_c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_c(input string name, input logic [15:0] exp);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        chk($sformatf("%s[%0d][%0d]", name, r, c), {16'h0, o_c[r][c]}, {16'h0, exp});
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input bit last,
                       input bit sgn, input logic [4:0] sh, input logic [7:0] d);
    for (int r = 0; r < ROWS; r++) i_a[r] = a;
    for (int c = 0; c < COLS; c++) begin
      i_b[c] = b;
      i_d[c] = d;
    end
    i_last      = last;
    i_signed    = sgn;
    i_shift     = sh;
    i_pre_valid = 1'b1;
  endtask

  // Returns #1 after the accepting edge.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input bit last,
                           input bit sgn, input logic [4:0] sh, input logic [7:0] d);
    int n;
    @(negedge clk);
    drive(a, b, last, sgn, sh, d);
    n = 0;
    while (!o_pre_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: o_pre_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    i_pre_valid = 1'b0;
    i_last      = 1'b0;
  endtask

  task automatic run_tile(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                          input bit sgn, input logic [4:0] sh, input int beats);
    for (int k = 0; k < beats; k++) send_beat(a, b, (k == beats - 1), sgn, sh, d);
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    i_post_ready = 1'b1;
    @(posedge clk);
    #1;
    i_post_ready = 1'b0;
    chk({name, "_valid_drop"}, {31'h0, o_post_valid}, 32'h0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{a:8'd2,   b:8'd3,   d:8'd0,   sgn:1'b0, sh:5'd0, beats:4,  exp_c:16'd24};
    vecs[1] = '{a:8'd127, b:8'd127, d:8'd0,   sgn:1'b1, sh:5'd0, beats:16, exp_c:16'h7FFF};
    vecs[2] = '{a:8'h80,  b:8'd127, d:8'd0,   sgn:1'b1, sh:5'd0, beats:16, exp_c:16'h8000};
    vecs[3] = '{a:8'd2,   b:8'd3,   d:8'd0,   sgn:1'b0, sh:5'd2, beats:1,  exp_c:16'd2};
    vecs[4] = '{a:8'd2,   b:8'd3,   d:8'd5,   sgn:1'b0, sh:5'd0, beats:1,  exp_c:16'd11};
    vecs[5] = '{a:8'hFE,  b:8'd3,   d:8'hFF,  sgn:1'b1, sh:5'd0, beats:1,  exp_c:16'hFFF9};
    vecs[6] = '{a:8'hFD,  b:8'd3,   d:8'd0,   sgn:1'b1, sh:5'd1, beats:1,  exp_c:16'hFFFC};
    vecs[7] = '{a:8'd255, b:8'd255, d:8'd0,   sgn:1'b0, sh:5'd0, beats:4,  exp_c:16'hFFFF};
    vecs[8] = '{a:8'd255, b:8'd255, d:8'd0,   sgn:1'b0, sh:5'd8, beats:16, exp_c:16'h0FE0};

    // reset state
    @(negedge clk);
    chk("rst_valid", {31'h0, o_post_valid}, 32'h0);
    chk("rst_ready", {31'h0, o_pre_ready}, 32'h1);
    chk("rst_ovf",   {31'h0, o_ovf}, 32'h0);
    chk_c("rst_c", 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven tiles
    for (int v = 0; v < 9; v++) begin
      run_tile(vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].sgn, vecs[v].sh, vecs[v].beats);
      chk($sformatf("vec%0d_valid", v), {31'h0, o_post_valid}, 32'h1);
      chk_c($sformatf("vec%0d_c", v), vecs[v].exp_c);
      chk($sformatf("vec%0d_ovf", v), {31'h0, o_ovf}, 32'h0);
      $display("tile %0d: a=%0h b=%0h d=%0h signed=%0d shift=%0d beats=%0d c00=%0h expected %0h",
               v, vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].sgn, vecs[v].sh, vecs[v].beats,
               o_c[0][0], vecs[v].exp_c);
      consume($sformatf("vec%0d", v));
    end

    // mode latched on first beat: -1*1 signed, then a beat marked unsigned
    send_beat(8'hFF, 8'd1, 1'b0, 1'b1, 5'd0, 8'd0);
    send_beat(8'hFF, 8'd1, 1'b1, 1'b0, 5'd0, 8'd0);
    chk_c("mode_latch_c", 16'hFFFE);
    $display("tile mode_latch: c00=%0h expected fffe", o_c[0][0]);
    consume("mode_latch");

    // stall with result pending, then back-to-back handover
    run_tile(8'd2, 8'd3, 8'd0, 1'b0, 5'd0, 4);
    @(negedge clk);
    drive(8'd1, 8'd1, 1'b1, 1'b0, 5'd0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_ready", k), {31'h0, o_pre_ready}, 32'h0);
      chk($sformatf("stall%0d_valid", k), {31'h0, o_post_valid}, 32'h1);
      chk($sformatf("stall%0d_c", k), {16'h0, o_c[1][2]}, 32'd24);
      @(negedge clk);
    end
    i_post_ready = 1'b1;
    @(posedge clk);
    #1;
    i_pre_valid  = 1'b0;
    i_last       = 1'b0;
    i_post_ready = 1'b0;
    chk("b2b_valid", {31'h0, o_post_valid}, 32'h1);
    chk_c("b2b_c", 16'd1);
    $display("tile b2b: c00=%0h expected 1", o_c[0][0]);
    consume("b2b");

    // reset mid-tile discards the partial sums
    send_beat(8'd5, 8'd5, 1'b0, 1'b0, 5'd0, 8'd0);
    send_beat(8'd5, 8'd5, 1'b0, 1'b0, 5'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'h0, o_post_valid}, 32'h0);
    rst_n = 1'b1;
    run_tile(8'd1, 8'd1, 8'd0, 1'b0, 5'd0, 1);
    chk_c("midrst_c", 16'd1);
    $display("tile after_reset: c00=%0h expected 1", o_c[0][0]);

    // reset while a result is pending
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("pendrst_valid", {31'h0, o_post_valid}, 32'h0);
    chk("pendrst_ready", {31'h0, o_pre_ready}, 32'h1);
    chk("pendrst_c", {16'h0, o_c[2][2]}, 32'h0);
    rst_n = 1'b1;

    // tile-length overflow
    for (int k = 1; k <= 17; k++) begin
      send_beat(8'd1, 8'd1, 1'b0, 1'b0, 5'd0, 8'd0);
      if (k == 16) chk("ovf_at16", {31'h0, o_ovf}, 32'h0);
      if (k == 17) chk("ovf_at17", {31'h0, o_ovf}, 32'h1);
    end
    send_beat(8'd1, 8'd1, 1'b1, 1'b0, 5'd0, 8'd0);
    chk_c("ovf_tile_c", 16'd18);
    chk("ovf_sticky", {31'h0, o_ovf}, 32'h1);
    $display("tile overflow: c00=%0h expected 12 ovf=%0d", o_c[0][0], o_ovf);
    consume("ovf_tile");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("ovf_rst", {31'h0, o_ovf}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matu_acc.md
MATU_ACC -- requirements
Module: matu_acc

Interface
REQ-001 SHALL have parameter ROWS, default 3, output rows (A-vector length).
REQ-002 SHALL have parameter COLS, default 3, output columns (B-vector length).
REQ-003 SHALL have parameter IN_WIDTH, default 8, operand width.
REQ-004 SHALL have parameter ACC_WIDTH, default 24, accumulator width.
REQ-005 SHALL have parameter OUT_WIDTH, default 16, result width.
REQ-006 SHALL have parameter KMAX, default 16, maximum beats per tile.
REQ-007 SHALL have port i_clk  in  1  the only clock; all state on rising edge.
REQ-008 SHALL have port i_rst  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port i_pre_valid  in  1  input beat valid.
REQ-010 SHALL have port o_pre_ready  out  1  input beat accepted when high with i_pre_valid.
REQ-011 SHALL have port i_a  in  [ROWS][IN_WIDTH]  column slice of A.
REQ-012 SHALL have port i_b  in  [COLS][IN_WIDTH]  row slice of B.
REQ-013 SHALL have port i_last  in  1  beat closes current tile.
REQ-014 SHALL have port i_signed  in  1  1 = two's-complement operands; sampled on first beat of tile.
REQ-015 SHALL have port i_shift  in  $clog2(ACC_WIDTH)  requant right shift; sampled on last beat.
REQ-016 SHALL have port i_d  in  [COLS][IN_WIDTH]  per-column bias; sampled on last beat, signedness per tile mode.
REQ-017 SHALL have port o_post_valid  out  1  result tile valid.
REQ-018 SHALL have port i_post_ready  in  1  consumer accepts result.
REQ-019 SHALL have port o_c  out  [ROWS][COLS][OUT_WIDTH]  result tile.
REQ-020 SHALL have port o_ovf  out  1  sticky tile-length overflow flag.

Function
REQ-021 SHALL accept a beat when i_pre_valid & o_pre_ready; o_pre_ready = ~o_post_valid | i_post_ready.
REQ-022 SHALL, per accepted beat, update acc[r][c] += i_a[r]*i_b[c] (full product, sign/zero extended to ACC_WIDTH, wrap in ACC_WIDTH).
REQ-023 SHALL implement FSM IDLE (acc zero, beat count 0) and ACC (tile open); IDLE->ACC on non-last beat, ACC->IDLE on last beat, IDLE->IDLE on single-beat tile.
REQ-024 SHALL, on last-beat acceptance, form acc+product+bias[c], add rounding 2^(i_shift-1) when i_shift>0, arithmetic (signed) or logical (unsigned) shift right by i_shift.
REQ-025 SHALL saturate result to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] signed or [0, 2^OUT_WIDTH-1] unsigned and register it into o_c.
REQ-026 SHALL assert o_post_valid the cycle after last-beat acceptance; latency 1 cycle.
REQ-027 SHALL clear accumulators and beat count at the same edge the result registers, so the next tile's first beat is accepted in the next cycle.
REQ-028 SHALL hold o_c and o_post_valid stable until i_post_ready; o_post_valid drops after handshake unless a new last beat is accepted same cycle, then o_c updates and o_post_valid stays high.
REQ-029 SHALL, while o_post_valid & ~i_post_ready, deassert o_pre_ready (accumulation stalls; acc held).
REQ-030 SHALL count beats per tile, saturating at KMAX; a non-last beat accepted when count==KMAX sets o_ovf and is still accumulated.
REQ-031 SHALL ignore i_signed changes mid-tile; tile mode is latched on first beat.

Reset
REQ-032 SHALL, on i_rst low (any time, including mid-tile or output pending), clear acc, count, FSM->IDLE, o_c=0, o_post_valid=0, o_ovf=0; o_pre_ready=1 after reset.
REQ-033 SHALL discard any partial tile across reset; no result for it is produced.

Structure
REQ-034 SHALL place FSM state enum and saturate/round width helpers in shared package matu_pkg.
REQ-035 SHALL use one sub-module, matu_requant (round, shift, saturate one element), instanced ROWS*COLS times.

Verification
REQ-036 Unsigned, a=2, b=3 all, 4 beats, last on 4th, shift 0, d=0 -> all o_c=24, o_post_valid next cycle.
REQ-037 Signed, 16 beats a=127,b=127 -> o_c=32767; a=-128,b=127 -> o_c=-32768; o_ovf stays 0.
REQ-038 Unsigned, 1 beat a=2,b=3, d=0, shift 2 -> o_c=2 (rounded 6/4); d=5, shift 0 -> o_c=11.
REQ-039 Hold i_post_ready=0 after tile -> o_pre_ready=0, o_c stable 5 cycles; raise ready with new tile pending -> back-to-back results, no loss.
REQ-040 Reset low after 2 beats, then 1-beat tile a=1,b=1 -> o_c=1; 17 non-last beats -> o_ovf=1 on 17th acceptance.
